// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath constants, accumulator sizing and state type
// Purpose: word widths, MNIST layer-1 geometry, accumulator width helper and
// the output saturation limit shared by the convolution stages.
// Ports: none (package).
package cnn_pkg;

    localparam int BW       = 16;
    localparam int WBW      = 8;
    localparam int FRAC     = 7;
    localparam int IN_SIZE  = 32;
    localparam int K_SIZE   = 5;
    localparam int OUT_SIZE = IN_SIZE - K_SIZE + 1;

    // 5 guard bits cover the growth of summing 25 products
    function automatic int acc_w(input int bw, input int wbw);
        return bw + wbw + 5;
    endfunction

    function automatic int sat_max(input int bw);
        return (1 << (bw - 1)) - 1;
    endfunction

    localparam int SAT_MAX = sat_max(BW);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } conv_state_e;

endpackage

// File: rtl/conv1_relu_stream_if.sv
// rtl/conv1_relu_stream_if.sv - weight/bias/pixel input and result output bundle
// Purpose: groups the load strobes, pixel stream and result stream of conv1.
// Ports (slave = conv1 side):
//   in : i_w_valid, i_w_data[WBW], i_b_valid, i_b_data[BW], i_valid, i_data[BW]
//   out: o_w_done, o_valid, o_data[BW], o_end
interface conv1_relu_stream_if #(
    parameter int BW  = cnn_pkg::BW,
    parameter int WBW = cnn_pkg::WBW
);
    import cnn_pkg::*;

    logic           i_w_valid;
    logic [WBW-1:0] i_w_data;
    logic           i_b_valid;
    logic [BW-1:0]  i_b_data;
    logic           i_valid;
    logic [BW-1:0]  i_data;
    logic           o_w_done;
    logic           o_valid;
    logic [BW-1:0]  o_data;
    logic           o_end;

    modport slave (
        input  i_w_valid, i_w_data, i_b_valid, i_b_data, i_valid, i_data,
        output o_w_done, o_valid, o_data, o_end
    );

    modport master (
        output i_w_valid, i_w_data, i_b_valid, i_b_data, i_valid, i_data,
        input  o_w_done, o_valid, o_data, o_end
    );

endinterface

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - enable-gated shift-register row buffer
// Purpose: delays a pixel by DEPTH accepted pixels (one image row).
// Ports: clk, global_rst_n (async active-low), en (shift), din[W], dout[W].
module conv_line_buffer #(
    parameter int W     = 16,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         global_rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    import cnn_pkg::*;

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv1_relu_stream.sv
// rtl/conv1_relu_stream.sv - streaming KxK conv + bias + rescale + ReLU/saturate
// Purpose: first CNN conv layer, one output channel; feeds maxpool1 directly.
// Ports: clk, global_rst_n (async active-low), rst (sync frame restart),
//        bus (conv1_relu_stream_if.slave: weight/bias load, pixels in, results out).
module conv1_relu_stream #(
    parameter int BW      = cnn_pkg::BW,
    parameter int WBW     = cnn_pkg::WBW,
    parameter int K_SIZE  = cnn_pkg::K_SIZE,
    parameter int IN_SIZE = cnn_pkg::IN_SIZE,
    parameter int FRAC    = cnn_pkg::FRAC
) (
    input  logic                  clk,
    input  logic                  global_rst_n,
    input  logic                  rst,
    conv1_relu_stream_if.slave    bus
);
    import cnn_pkg::*;

    localparam int OUT_SIZE = IN_SIZE - K_SIZE + 1;
    localparam int EDGE     = IN_SIZE - OUT_SIZE;
    localparam int NTAP     = K_SIZE * K_SIZE;
    localparam int WCNT_W   = $clog2(NTAP);
    localparam int POS_W    = $clog2(IN_SIZE);
    localparam int PW       = BW + WBW;
    localparam int ACC_W    = acc_w(BW, WBW);
    localparam int POST_W   = ACC_W + 1;
    localparam logic signed [POST_W-1:0] POST_MAX = POST_W'(sat_max(BW));
    localparam logic [BW-1:0]            OUT_MAX  = BW'(sat_max(BW));

    conv_state_e              state_q, state_d;
    logic [WCNT_W-1:0]        wcnt;
    logic signed [WBW-1:0]    weight [NTAP];
    logic signed [BW-1:0]     bias_q;
    logic [POS_W-1:0]         col, row;
    logic                     accept, win_done, last_pix;
    logic [BW-1:0]            lb_in  [K_SIZE-1];
    logic [BW-1:0]            lb_out [K_SIZE-1];
    logic signed [BW-1:0]     win [K_SIZE][K_SIZE];
    logic signed [PW-1:0]     prod [NTAP];
    logic signed [ACC_W-1:0]  sum_c, sum_q, shifted;
    logic signed [POST_W-1:0] post_c;
    logic [BW-1:0]            sat_c;
    logic                     v0, v1, v2, e0, e1, e2;
    logic                     o_valid_q, o_end_q;
    logic [BW-1:0]            o_data_q;

    // Weight-load FSM: S_RUN is terminal until global reset
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) state_q <= S_LOAD;
        else               state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_LOAD && bus.i_w_valid && wcnt == WCNT_W'(NTAP - 1))
            state_d = S_RUN;
    end

    assign bus.o_w_done = (state_q == S_RUN);

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            wcnt <= '0;
            for (int i = 0; i < NTAP; i++) weight[i] <= '0;
        end else if (state_q == S_LOAD && bus.i_w_valid) begin
            weight[wcnt] <= signed'(bus.i_w_data);
            wcnt         <= wcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n)      bias_q <= '0;
        else if (bus.i_b_valid) bias_q <= signed'(bus.i_b_data);
    end

    // rst wins over i_valid: a pixel presented with rst is dropped
    assign accept   = bus.i_valid && (state_q == S_RUN) && !rst;
    assign win_done = (row >= POS_W'(EDGE)) && (col >= POS_W'(EDGE));
    assign last_pix = (row == POS_W'(IN_SIZE - 1)) && (col == POS_W'(IN_SIZE - 1));

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n || rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == POS_W'(IN_SIZE - 1)) begin
                col <= '0;
                row <= last_pix ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // lb_out[j] is the pixel j+1 rows above the incoming one, same column
    for (genvar j = 0; j < K_SIZE - 1; j++) begin : g_lb
        if (j == 0) begin : g_head
            assign lb_in[j] = bus.i_data;
        end else begin : g_chain
            assign lb_in[j] = lb_out[j-1];
        end
        conv_line_buffer #(.W(BW), .DEPTH(IN_SIZE)) u_lb (
            .clk          (clk),
            .global_rst_n (global_rst_n),
            .en           (accept),
            .din          (lb_in[j]),
            .dout         (lb_out[j])
        );
    end

    // win[0] is the oldest row, win[*][K_SIZE-1] the newest column
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            for (int r = 0; r < K_SIZE; r++)
                for (int c = 0; c < K_SIZE; c++) win[r][c] <= '0;
        end else if (accept) begin
            for (int r = 0; r < K_SIZE; r++)
                for (int c = 0; c < K_SIZE - 1; c++) win[r][c] <= win[r][c+1];
            win[K_SIZE-1][K_SIZE-1] <= signed'(bus.i_data);
            for (int j = 0; j < K_SIZE - 1; j++)
                win[K_SIZE-2-j][K_SIZE-1] <= signed'(lb_out[j]);
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NTAP; i++) sum_c = sum_c + ACC_W'(prod[i]);
    end

    always_comb begin
        shifted = sum_q >>> FRAC;
        post_c  = POST_W'(shifted) + POST_W'(bias_q);
        if (post_c[POST_W-1])       sat_c = '0;
        else if (post_c > POST_MAX) sat_c = OUT_MAX;
        else                        sat_c = post_c[BW-1:0];
    end

    // Data path registers run every cycle; only the valid/end tags matter
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            for (int i = 0; i < NTAP; i++) prod[i] <= '0;
            sum_q <= '0;
        end else begin
            for (int r = 0; r < K_SIZE; r++)
                for (int c = 0; c < K_SIZE; c++)
                    prod[r*K_SIZE+c] <= PW'(win[r][c]) * PW'(weight[r*K_SIZE+c]);
            sum_q <= sum_c;
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            {v0, v1, v2, e0, e1, e2} <= '0;
            o_valid_q <= 1'b0;
            o_end_q   <= 1'b0;
            o_data_q  <= '0;
        end else if (rst) begin
            {v0, v1, v2, e0, e1, e2} <= '0;
            o_valid_q <= 1'b0;
            o_end_q   <= 1'b0;
        end else begin
            v0        <= accept && win_done;
            e0        <= accept && last_pix;
            v1        <= v0;
            e1        <= e0;
            v2        <= v1;
            e2        <= e1;
            o_valid_q <= v2;
            o_end_q   <= v2 && e2;
            if (v2) o_data_q <= sat_c;
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_end   = o_end_q;
    assign bus.o_data  = o_data_q;

endmodule

// File: tb/tb_conv1_relu_stream.sv
// tb/tb_conv1_relu_stream.sv - directed self-checking bench for conv1_relu_stream
module tb_conv1_relu_stream;

    // +128 (1.0 with 7 fractional bits) needs a 9-bit signed weight
    localparam int TB_WBW = 9;
    localparam int NOUT   = 784;

    logic clk = 1'b0;
    logic global_rst_n;
    logic rst;

    always #5 clk = ~clk;

    conv1_relu_stream_if #(.BW(16), .WBW(TB_WBW)) bus();

    conv1_relu_stream #(.WBW(TB_WBW)) dut (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .rst          (rst),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int outq[$];
    int outcyc[$];
    int endcnt;
    int endpos;
    int acc44;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.o_valid === 1'b1) begin
            outq.push_back(int'(bus.o_data));
            outcyc.push_back(cyc);
        end
        if (bus.o_end === 1'b1) begin
            endcnt++;
            endpos = outq.size();
        end
    endtask

    task automatic reset_outs();
        outq.delete();
        outcyc.delete();
        endcnt = 0;
        endpos = -1;
    endtask

    function automatic logic [TB_WBW-1:0] wval(input int mode, input int i);
        case (mode)
            0:       return (i == 12) ? 9'd128 : 9'd0;
            1:       return 9'd128;
            2:       return 9'd127;
            default: return (i == 12) ? 9'h180 : 9'd0;
        endcase
    endfunction

    task automatic load_weights(input int mode);
        for (int i = 0; i < 25; i++) begin
            bus.i_w_valid = 1'b1;
            bus.i_w_data  = wval(mode, i);
            tick();
        end
        bus.i_w_valid = 1'b0;
    endtask

    task automatic send_frame(input int ramp, input int cval, input int npix,
                              input int gaps, input int wjunk);
        for (int p = 0; p < npix; p++) begin
            bus.i_w_valid = wjunk[0];
            bus.i_w_data  = 9'h0ff;
            if (gaps != 0 && $urandom_range(0, 3) == 0) begin
                bus.i_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            bus.i_valid = 1'b1;
            bus.i_data  = (ramp != 0) ? 16'((p / 32) * 32 + (p % 32)) : 16'(cval);
            tick();
            if (p == 4 * 32 + 4) acc44 = cyc;
        end
        bus.i_valid   = 1'b0;
        bus.i_w_valid = 1'b0;
    endtask

    task automatic check_ident(input string tag);
        int bad;
        int n;
        bad = 0;
        n = (outq.size() < NOUT) ? outq.size() : NOUT;
        for (int k = 0; k < n; k++)
            if (outq[k] != (k / 28 + 2) * 32 + (k % 28 + 2)) bad++;
        chk({tag, "_count"}, outq.size(), NOUT);
        chk({tag, "_bad_values"}, bad, 0);
        chk({tag, "_end_count"}, endcnt, 1);
        chk({tag, "_end_pos"}, endpos, NOUT);
    endtask

    task automatic check_const(input string tag, input int val);
        int bad;
        bad = 0;
        foreach (outq[k]) if (outq[k] != val) bad++;
        chk({tag, "_count"}, outq.size(), NOUT);
        chk({tag, "_bad_values"}, bad, 0);
        chk({tag, "_end_count"}, endcnt, 1);
    endtask

    task automatic pulse_global_reset();
        global_rst_n = 1'b0;
        repeat (2) tick();
        global_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        global_rst_n  = 1'b0;
        rst           = 1'b0;
        bus.i_w_valid = 1'b0;
        bus.i_w_data  = '0;
        bus.i_b_valid = 1'b0;
        bus.i_b_data  = '0;
        bus.i_valid   = 1'b0;
        bus.i_data    = '0;
        reset_outs();
        repeat (3) tick();
        chk("reset_o_valid", bus.o_valid, 0);
        chk("reset_o_data", bus.o_data, 0);
        chk("reset_o_end", bus.o_end, 0);
        chk("reset_o_w_done", bus.o_w_done, 0);
        global_rst_n = 1'b1;
        tick();

        // Pixels presented while weights load must be dropped
        reset_outs();
        for (int i = 0; i < 25; i++) begin
            bus.i_w_valid = 1'b1;
            bus.i_w_data  = wval(0, i);
            bus.i_valid   = 1'b1;
            bus.i_data    = 16'(256 + i);
            tick();
            if (i == 23) chk("w_done_before_25th", bus.o_w_done, 0);
        end
        chk("w_done_after_25th", bus.o_w_done, 1);
        bus.i_w_valid = 1'b0;
        bus.i_valid   = 1'b0;
        repeat (4) tick();
        chk("load_gate_no_valid", outq.size(), 0);

        // Identity kernel, back-to-back ramp
        reset_outs();
        send_frame(1, 0, 1024, 0, 0);
        repeat (6) tick();
        check_ident("ident");
        chk("ident_first", (outq.size() > 0) ? outq[0] : -1, 66);
        chk("ident_last", (outq.size() > 0) ? outq[outq.size()-1] : -1, 957);
        chk("ident_latency", (outcyc.size() > 0) ? outcyc[0] - acc44 : -1, 3);
        chk("ident_row_contig", (outcyc.size() > 28) ? outcyc[27] - outcyc[0] : -1, 27);
        chk("ident_row_gap", (outcyc.size() > 28) ? outcyc[28] - outcyc[27] : -1, 5);

        // Random input gaps plus weight strobes while running
        reset_outs();
        send_frame(1, 0, 1024, 1, 1);
        repeat (6) tick();
        check_ident("stall");

        // Synchronous restart after 500 pixels; rst-cycle pixel is dropped
        reset_outs();
        send_frame(1, 0, 500, 0, 0);
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 16'h1234;
        tick();
        chk("rst_o_valid_low", bus.o_valid, 0);
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        reset_outs();
        repeat (4) tick();
        chk("rst_no_trailing_valid", outq.size(), 0);
        reset_outs();
        send_frame(1, 0, 1024, 0, 0);
        repeat (6) tick();
        check_ident("after_rst");

        // Global reset mid-frame acts immediately
        send_frame(1, 0, 300, 0, 0);
        global_rst_n = 1'b0;
        #1;
        chk("grst_o_valid", bus.o_valid, 0);
        chk("grst_o_data", bus.o_data, 0);
        chk("grst_o_w_done", bus.o_w_done, 0);
        repeat (2) tick();
        global_rst_n = 1'b1;
        tick();

        // Box kernel, then negative bias drives ReLU to zero
        load_weights(1);
        reset_outs();
        send_frame(0, 1, 1024, 0, 0);
        repeat (6) tick();
        check_const("box", 25);
        bus.i_b_valid = 1'b1;
        bus.i_b_data  = 16'hffe2;
        tick();
        bus.i_b_valid = 1'b0;
        reset_outs();
        send_frame(0, 1, 1024, 0, 0);
        repeat (6) tick();
        check_const("box_bias", 0);

        // Positive saturation
        pulse_global_reset();
        load_weights(2);
        reset_outs();
        send_frame(0, 32767, 1024, 0, 0);
        repeat (6) tick();
        check_const("sat_pos", 32767);

        // Negative result clamps to zero
        pulse_global_reset();
        load_weights(3);
        reset_outs();
        send_frame(0, 5, 1024, 0, 0);
        repeat (6) tick();
        check_const("relu_neg", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
